// File: rtl/serial_crc_ccitt_checker.sv
// ---------------------------------------------------------------------------
// serial_crc_ccitt_checker
//
// Receive-side CRC-CCITT checker. A frame is a programmable number of payload
// bits followed by the 16-bit CRC appended by the transmitter, both MSB-first.
// The payload is run through the CRC LFSR (poly 0x1021, no reflection, no
// final XOR), the trailing 16 bits are captured as the received CRC, and a
// one-cycle done pulse reports whether the two match.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      one-cycle pulse: begin a new frame, samples data_bits
//   data_bits  payload length in bits (CRC bits excluded)
//   enable     bit strobe, data_in valid this cycle
//   data_in    serial bit, MSB-first
//   busy       high from the cycle after start until done
//   done       one-cycle pulse when the frame check completes
//   crc_ok     received CRC equals computed CRC (valid from done to next start)
//   crc_calc   CRC computed over the payload
//   crc_rx     CRC captured from the stream
// ---------------------------------------------------------------------------
module serial_crc_ccitt_checker #(
    parameter int          LEN_W    = 16,
    parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] data_bits,
    input  logic             enable,
    input  logic             data_in,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic [15:0]      crc_calc,
    output logic [15:0]      crc_rx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CRC  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // The bit counter is reused for the 16 CRC bits, so LEN_W must be >= 5.
    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] CNT_CRC  = LEN_W'(16);
    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};

    // One MSB-first step of the CRC-CCITT LFSR.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    state_t           state_r, state_s;
    logic [LEN_W-1:0] cnt_r, cnt_s;
    logic [15:0]      crc_calc_r, crc_calc_s;
    logic [15:0]      crc_rx_r, crc_rx_s;
    logic             crc_ok_r, crc_ok_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;

    // Next-state and next-value logic for the frame FSM and datapath.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        crc_calc_s = crc_calc_r;
        crc_rx_s   = crc_rx_r;
        crc_ok_s   = crc_ok_r;

        if (start) begin
            // start wins over everything, including a same-cycle bit strobe
            // and an in-flight frame (which is silently abandoned).
            crc_calc_s = CRC_INIT;
            crc_rx_s   = 16'h0000;
            crc_ok_s   = 1'b0;
            if (data_bits != CNT_ZERO) begin
                state_s = ST_DATA;
                cnt_s   = data_bits;
            end else begin
                state_s = ST_CRC;
                cnt_s   = CNT_CRC;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_DATA: begin
                    if (enable) begin
                        crc_calc_s = crc_step(crc_calc_r, data_in);
                        if (cnt_r == CNT_ONE) begin
                            state_s = ST_CRC;
                            cnt_s   = CNT_CRC;
                        end else begin
                            cnt_s = cnt_r - CNT_ONE;
                        end
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_CRC: begin
                    if (enable) begin
                        crc_rx_s = {crc_rx_r[14:0], data_in};
                        if (cnt_r == CNT_ONE) begin
                            state_s  = ST_DONE;
                            cnt_s    = CNT_ZERO;
                            // Compare against the fully shifted value so the
                            // verdict is ready in the same cycle as done.
                            crc_ok_s = (crc_calc_r == {crc_rx_r[14:0], data_in});
                        end else begin
                            cnt_s = cnt_r - CNT_ONE;
                        end
                    end else begin
                        state_s = ST_CRC;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        // Status outputs are registered copies of the next state.
        busy_s = (state_s == ST_DATA) || (state_s == ST_CRC);
        done_s = (state_s == ST_DONE);
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            crc_calc_r <= CRC_INIT;
            crc_rx_r   <= 16'h0000;
            crc_ok_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            crc_calc_r <= crc_calc_s;
            crc_rx_r   <= crc_rx_s;
            crc_ok_r   <= crc_ok_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign crc_ok   = crc_ok_r;
    assign crc_calc = crc_calc_r;
    assign crc_rx   = crc_rx_r;

endmodule

// File: tb/tb_serial_crc_ccitt_checker.sv
// ---------------------------------------------------------------------------
// tb_serial_crc_ccitt_checker
//
// Directed and randomized frames for serial_crc_ccitt_checker. Expected CRCs
// come from a reference function applied to the bit stream the bench builds;
// the received CRC is the last 16 bits the bench itself sent.
// ---------------------------------------------------------------------------
module tb_serial_crc_ccitt_checker;

    localparam int LEN_W = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] data_bits;
    logic             enable;
    logic             data_in;
    logic             busy;
    logic             done;
    logic             crc_ok;
    logic [15:0]      crc_calc;
    logic [15:0]      crc_rx;

    int checks;
    int errors;
    int done_cnt;
    bit stream_q[$];

    serial_crc_ccitt_checker #(.LEN_W(LEN_W), .CRC_INIT(16'hFFFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .data_bits(data_bits),
        .enable   (enable),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .crc_ok   (crc_ok),
        .crc_calc (crc_calc),
        .crc_rx   (crc_rx)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every done pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Hard bound on total run time.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) stream_q.push_back(b[i]);
    endtask

    task automatic push16(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) stream_q.push_back(w[i]);
    endtask

    task automatic push_123456789();
        stream_q.delete();
        for (int c = 8'h31; c <= 8'h39; c++) push_byte(8'(c));
    endtask

    // CRC-CCITT (poly x^16+x^12+x^5+1, seed FFFF) as long division of the
    // first n stream bits, one message bit at a time.
    function automatic logic [15:0] crc_ref(input int n);
        logic [16:0] rem;
        rem = {1'b0, 16'hFFFF};
        for (int i = 0; i < n; i++) begin
            rem = {rem[15:0], 1'b0};
            if ((rem[16] ^ stream_q[i]) == 1'b1) rem = rem ^ 17'h11021;
            else rem = {1'b0, rem[15:0]};
        end
        return rem[15:0];
    endfunction

    function automatic logic [15:0] rx_ref(input int n);
        logic [15:0] v;
        v = 16'h0000;
        for (int i = 0; i < 16; i++) v = {v[14:0], stream_q[n + i]};
        return v;
    endfunction

    task automatic do_start(input int n, input logic en, input logic din);
        start     = 1'b1;
        data_bits = LEN_W'(n);
        enable    = en;
        data_in   = din;
        tick();
        start   = 1'b0;
        enable  = 1'b0;
        data_in = 1'b0;
    endtask

    // Send stream bits [lo,hi) with a random number of idle cycles before each.
    task automatic send_bits(input int lo, input int hi, input int min_gap, input int max_gap);
        int gap;
        for (int i = lo; i < hi; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(min_gap, max_gap)) : 0;
            for (int g = 0; g < gap; g++) begin
                enable  = 1'b0;
                data_in = 1'($urandom);
                tick();
                check("busy_in_gap", busy, 1'b1);
            end
            enable  = 1'b1;
            data_in = stream_q[i];
            tick();
            enable  = 1'b0;
        end
    endtask

    // Called right after the last CRC bit was strobed.
    task automatic check_done(input string tag, input int n);
        logic [15:0] exp_calc;
        logic [15:0] exp_rx;
        exp_calc = crc_ref(n);
        exp_rx   = rx_ref(n);
        check({tag, "_done"},   done,     1'b1);
        check({tag, "_busy0"},  busy,     1'b0);
        check({tag, "_calc"},   crc_calc, exp_calc);
        check({tag, "_rx"},     crc_rx,   exp_rx);
        check({tag, "_ok"},     crc_ok,   (exp_calc == exp_rx));
        tick();
        check({tag, "_done_lo"}, done,     1'b0);
        check({tag, "_hold_ok"}, crc_ok,   (exp_calc == exp_rx));
        check({tag, "_hold_rx"}, crc_rx,   exp_rx);
    endtask

    initial begin
        int n;
        int d0;
        logic [15:0] c;

        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        reset     = 1'b1;
        start     = 1'b0;
        data_bits = '0;
        enable    = 1'b0;
        data_in   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state.
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ok",   crc_ok, 1'b0);
        check("rst_calc", crc_calc, 16'hFFFF);
        check("rst_rx",   crc_rx, 16'h0000);

        // Bit strobes in IDLE are ignored.
        for (int i = 0; i < 12; i++) begin
            enable  = 1'($urandom);
            data_in = 1'($urandom);
            tick();
        end
        enable = 1'b0;
        check("idle_busy", busy, 1'b0);
        check("idle_calc", crc_calc, 16'hFFFF);
        check("idle_rx",   crc_rx, 16'h0000);
        check("idle_done_cnt", done_cnt, 0);

        // Standard check value.
        push_123456789();
        push16(16'h29B1);
        do_start(72, 1'b0, 1'b0);
        check("std_busy", busy, 1'b1);
        send_bits(0, 88, 0, 0);
        check("std_calc_const", crc_calc, 16'h29B1);
        check("std_ok_const",   crc_ok, 1'b1);
        check_done("std", 72);

        // Corrupted payload bit 5.
        push_123456789();
        push16(16'h29B1);
        stream_q[5] = ~stream_q[5];
        do_start(72, 1'b0, 1'b0);
        send_bits(0, 88, 0, 0);
        check("bad_pl_rx",   crc_rx, 16'h29B1);
        check("bad_pl_ok",   crc_ok, 1'b0);
        check("bad_pl_diff", (crc_calc != 16'h29B1), 1'b1);
        check_done("bad_pl", 72);

        // Corrupted CRC field.
        push_123456789();
        push16(16'h29B0);
        do_start(72, 1'b0, 1'b0);
        send_bits(0, 88, 0, 0);
        check("bad_crc_ok", crc_ok, 1'b0);
        check_done("bad_crc", 72);

        // "A" with sparse strobes.
        stream_q.delete();
        push_byte(8'h41);
        push16(16'hB915);
        do_start(8, 1'b0, 1'b0);
        send_bits(0, 24, 2, 5);
        check("a_ok_const", crc_ok, 1'b1);
        check_done("a", 8);

        // Empty payload: CRC field only.
        stream_q.delete();
        push16(16'hFFFF);
        do_start(0, 1'b0, 1'b0);
        check("zero_busy", busy, 1'b1);
        send_bits(0, 16, 0, 1);
        check("zero_calc", crc_calc, 16'hFFFF);
        check_done("zero", 0);

        // Random frames, alternately good and with a flipped CRC bit.
        for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(1, 40));
            stream_q.delete();
            for (int i = 0; i < n; i++) stream_q.push_back(1'($urandom));
            c = crc_ref(n);
            if ((f % 2) == 1) c = c ^ (16'h0001 << $urandom_range(0, 15));
            push16(c);
            do_start(n, 1'b0, 1'b0);
            send_bits(0, n + 16, 0, 2);
            check_done("rand", n);
        end

        // Restart mid-payload: only the second frame reports.
        d0 = done_cnt;
        push_123456789();
        push16(16'h29B1);
        do_start(72, 1'b0, 1'b0);
        send_bits(0, 20, 0, 0);
        do_start(72, 1'b0, 1'b0);
        check("abort_calc_reinit", crc_calc, 16'hFFFF);
        send_bits(0, 88, 0, 0);
        check_done("abort", 72);
        check("abort_one_done", done_cnt - d0, 1);

        // Reset during the CRC phase.
        d0 = done_cnt;
        do_start(72, 1'b0, 1'b0);
        send_bits(0, 77, 0, 0);
        check("mid_rst_busy_before", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ok",   crc_ok, 1'b0);
        check("mid_rst_calc", crc_calc, 16'hFFFF);
        check("mid_rst_rx",   crc_rx, 16'h0000);
        send_bits(77, 88, 0, 0);
        tick();
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_idle_busy", busy, 1'b0);

        // Start coincident with a strobed 1: that bit is dropped.
        do_start(72, 1'b1, 1'b1);
        send_bits(0, 88, 0, 0);
        check("coinc_ok_const", crc_ok, 1'b1);
        check_done("coinc", 72);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
